// File: rtl/ctrl_pkg.sv
// Shared controller encodings used by the datapath and memory-stage blocks.
package ctrl_pkg;

  localparam logic MemRW_L = 1'b0;
  localparam logic MemRW_S = 1'b1;

endpackage

// File: rtl/dmem_pkg.sv
// Data-memory shared types: store-buffer entry record and default buffer depth.
package dmem_pkg;

  localparam int unsigned WBUF_DEPTH = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_match.sv
// Youngest-match search over the store buffer for load forwarding.
module wbuf_match
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = WBUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  wbuf_entry_t      entries_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PTR_W-1:0] head_i,
  input  logic [29:0]      addr_i,
  output logic             hit_o,
  output logic [31:0]      data_o
);

  // Walk oldest to youngest starting at head so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    hit_o  = 1'b0;
    data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (valid_i[idx] && (entries_i[idx].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Store buffer between the memory stage and backing data memory, draining
// stores in program order and forwarding buffered data to loads.
module dmem_write_buffer
  import ctrl_pkg::*;
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_data,
  input  logic [31:0] s_data,
  input  logic        mem_rw,
  output logic [31:0] l_data,
  output logic [29:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        wr_valid,
  output logic [29:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  wbuf_entry_t      entries_q [DEPTH];
  logic [DEPTH-1:0] valid_mask;
  logic             store, enq, deq;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr_data[1:0];

  assign store    = (mem_rw == MemRW_S);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_valid = !empty;
  assign overflow = ovf_q;
  assign deq      = wr_valid && wr_ready;
  // A full buffer still takes a store when the head leaves in the same cycle.
  assign enq      = store && (!full || deq);

  assign wr_addr  = entries_q[head_q].addr;
  assign wr_data  = entries_q[head_q].data;
  assign rd_addr  = addr_data[31:2];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (store && !enq) begin
      ovf_d = 1'b1;
    end
  end

  // Slot s is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset     = '0;
    valid_mask = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      offset        = PTR_W'(s) - head_q;
      valid_mask[s] = ({1'b0, offset} < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q] <= '{addr: addr_data[31:2], data: s_data};
    end
  end

  wbuf_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries_i (entries_q),
    .valid_i   (valid_mask),
    .head_i    (head_q),
    .addr_i    (addr_data[31:2]),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign l_data = fwd_hit ? fwd_data : rd_data;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Store-buffer bench: directed scenarios plus random traffic against a queue model.
module tb_dmem_write_buffer;
  import ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_data, s_data, rd_data;
  logic        mem_rw, wr_ready;
  logic [31:0] l_data, wr_data;
  logic [29:0] rd_addr, wr_addr;
  logic        wr_valid, full, empty, overflow;

  int checks   = 0;
  int failures = 0;

  logic [29:0] q_addr [$];
  logic [31:0] q_data [$];
  logic        m_ovf;

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_data (addr_data),
    .s_data    (s_data),
    .mem_rw    (mem_rw),
    .l_data    (l_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [29:0] a, input logic [31:0] rdd);
    logic [31:0] r;
    r = rdd;
    foreach (q_addr[i]) if (q_addr[i] == a) r = q_data[i];
    return r;
  endfunction

  task automatic check_outputs();
    int n;
    n = q_addr.size();
    check_val("l_data", l_data, model_load(addr_data[31:2], rd_data));
    check_val("rd_addr", 32'(rd_addr), 32'(addr_data[31:2]));
    check_val("wr_valid", 32'(wr_valid), 32'(n != 0));
    check_val("full", 32'(full), 32'(n == DEPTH));
    check_val("empty", 32'(empty), 32'(n == 0));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    if (n != 0) begin
      check_val("wr_addr", 32'(wr_addr), 32'(q_addr[0]));
      check_val("wr_data", wr_data, q_data[0]);
    end
  endtask

  task automatic cycle(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdd, input logic rdy);
    logic full_b, deq;
    @(negedge clk);
    mem_rw    = st ? MemRW_S : MemRW_L;
    addr_data = a;
    s_data    = d;
    rd_data   = rdd;
    wr_ready  = rdy;
    #1 check_outputs();
    @(posedge clk);
    full_b = (q_addr.size() == DEPTH);
    deq    = (q_addr.size() != 0) && rdy;
    if (deq) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (st) begin
      if (!full_b || deq) begin
        q_addr.push_back(a[31:2]);
        q_data.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; mem_rw = MemRW_L; wr_ready = 1'b0;
    addr_data = '0; s_data = '0; rd_data = '0;
    m_ovf = 1'b0;
    #12;
    check_val("rst_wr_valid", 32'(wr_valid), 32'd0);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #2 rst = 1'b1;

    // first store directly after reset, then forward it
    cycle(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    #1;
    check_val("st_wr_valid", 32'(wr_valid), 32'd1);
    check_val("st_wr_addr", 32'(wr_addr), 32'h040);
    check_val("st_wr_data", wr_data, 32'hDEADBEEF);
    check_val("st_empty", 32'(empty), 32'd0);
    cycle(1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
    #1 check_val("fwd_head", l_data, 32'hDEADBEEF);

    // youngest of two same-address stores wins; drain in order
    cycle(1'b1, 32'h200, 32'd1, 32'h0, 1'b0);
    cycle(1'b1, 32'h200, 32'd2, 32'h0, 1'b0);
    cycle(1'b0, 32'h200, 32'h0, 32'h5555AAAA, 1'b0);
    #1 check_val("fwd_youngest", l_data, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    #1 check_val("drained_empty", 32'(empty), 32'd1);

    cycle(1'b0, 32'h300, 32'h0, 32'h12345678, 1'b0);
    #1 check_val("miss_rd_data", l_data, 32'h12345678);

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h400 + 32'(i * 4), 32'hA0 + 32'(i), $urandom, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    check_val("stream_ovf", 32'(overflow), 32'd0);
    check_val("stream_empty", 32'(empty), 32'd1);

    // fill, drop, then store-while-draining at full
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h500 + 32'(i * 4), 32'hB0 + 32'(i), 32'h0, 1'b0);
    #1 check_val("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 32'h600, 32'hBAD, 32'h0, 1'b0);
    #1;
    check_val("drop_ovf", 32'(overflow), 32'd1);
    check_val("drop_full", 32'(full), 32'd1);
    cycle(1'b1, 32'h604, 32'hC6, 32'h0, 1'b1);
    #1 check_val("full_swap_full", 32'(full), 32'd1);
    cycle(1'b0, 32'h600, 32'h0, 32'h77, 1'b0);

    // async reset with three pending and a handshake in flight
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    mem_rw = MemRW_L; wr_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_val("arst_wr_valid", 32'(wr_valid), 32'd0);
    check_val("arst_empty", 32'(empty), 32'd1);
    check_val("arst_ovf", 32'(overflow), 32'd0);
    q_addr.delete(); q_data.delete(); m_ovf = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    cycle(1'b0, 32'h508, 32'h0, 32'h600DF00D, 1'b0);
    #1 check_val("arst_load_miss", l_data, 32'h600DF00D);

    // random traffic: low drain rate first, then high
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic        rdy;
      a   = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle(1'($urandom_range(0, 1)), a, $urandom, $urandom, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 DEPTH, 4, number of buffered store entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 addr_data  input  32  memory-stage byte address from the datapath; bits [1:0] ignored.
REQ-005 s_data  input  32  memory-stage store data, already width-selected by the datapath.
REQ-006 mem_rw  input  1  memory-stage direction: MemRW_S = store, MemRW_L = load/idle.
REQ-007 l_data  output  32  load data returned to the datapath, combinational.
REQ-008 rd_addr  output  30  backing-memory read word address, equal to addr_data[31:2], combinational.
REQ-009 rd_data  input  32  backing-memory combinational read data for rd_addr.
REQ-010 wr_valid  output  1  drain request to backing memory; high while the buffer is not empty.
REQ-011 wr_addr  output  30  word address of the head entry.
REQ-012 wr_data  output  32  data of the head entry.
REQ-013 wr_ready  input  1  backing memory accepts the head entry this cycle.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow  output  1  sticky flag: a store was dropped.

Function
REQ-017 The block SHALL hold a circular FIFO of DEPTH entries {word addr[29:0], data[31:0]}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-018 Enqueue: at a rising edge with mem_rw == MemRW_S, the block SHALL write {addr_data[31:2], s_data} at tail, then advance tail and increment count.
REQ-019 Dequeue: at a rising edge with wr_valid && wr_ready, the block SHALL advance head and decrement count.
REQ-020 On simultaneous enqueue and dequeue, count SHALL stay unchanged and both pointers SHALL advance; this is permitted when full.
REQ-021 An enqueue when full without a same-cycle dequeue SHALL be dropped, SHALL leave the FIFO unchanged, and SHALL set overflow; overflow SHALL clear only on reset.
REQ-022 While wr_valid is high and wr_ready is low, wr_addr and wr_data SHALL hold stable.
REQ-023 Stores SHALL drain in program order, one per accepted handshake.
REQ-024 Stores SHALL NOT be coalesced.
REQ-025 Load forwarding: l_data SHALL equal the data of the youngest valid entry whose addr == addr_data[31:2], else rd_data; this is purely combinational with zero latency.
REQ-026 The head entry SHALL remain forwardable in the cycle it is dequeued.
REQ-027 A store enqueued at edge N SHALL be visible to loads from the cycle after edge N.
REQ-028 Forwarding SHALL be evaluated regardless of mem_rw; the datapath ignores l_data for non-loads.
REQ-029 When count == 0, wr_valid SHALL be 0 and wr_addr/wr_data are don't-care.

Reset
REQ-030 While rst is low: head = tail = 0, count = 0, overflow = 0, hence wr_valid = 0, full = 0, empty = 1.
REQ-031 Entry storage SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all pending stores, including a handshake in flight.
REQ-033 The first enqueue SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-034 MemRW_S/MemRW_L SHALL come from the existing shared controller code header.
REQ-035 The entry record type and DEPTH default SHALL live in a new shared package, dmem_pkg.
REQ-036 The youngest-match priority search SHALL be one sub-module, wbuf_match: DEPTH entries, valid mask and head in; hit and data out.
REQ-037 Valid mask SHALL be derived from head/count, not stored per entry.

Verification
REQ-038 Post-reset, drive store 0x100 <- 0xDEADBEEF with wr_ready = 0 -> next cycle wr_valid = 1, wr_addr = 0x040, wr_data = 0xDEADBEEF, empty = 0; load 0x100 gives l_data = 0xDEADBEEF while rd_data = 0.
REQ-039 Stores 0x200 <- 1, then 0x200 <- 2, wr_ready = 0 -> load 0x200 returns 2; raise wr_ready -> drains 1 then 2 in order, then empty = 1.
REQ-040 Fill 4 stores with wr_ready = 0 -> full = 1; a 5th store is dropped, overflow = 1, count stays 4; a 6th store with wr_ready = 1 in the same cycle is accepted and count stays 4.
REQ-041 Run 10 store/drain cycles with wr_ready = 1 continuously -> pointers wrap, every write appears on wr_* exactly once, in order, and overflow = 0.
REQ-042 Load a word absent from the buffer with rd_data = 0x12345678 -> l_data = 0x12345678.
REQ-043 With 3 entries pending, pulse rst low asynchronously mid-cycle -> wr_valid drops immediately, empty = 1, overflow = 0, and later loads return rd_data.
